// File: rtl/rf_read_arbiter.sv
// Arbitrates the single register-file read port between core, debug and the register-dump engine.
// Define RF_ARB_DUMP_EN to build the dump engine; without it the dump outputs are tied to zero.
module rf_read_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic [4:0]  c_addr,
  output logic        c_gnt,
  output logic        c_rvalid,
  input  logic        d_req,
  input  logic [4:0]  d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  input  logic        dump_start,
  output logic        dump_busy,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic [4:0]  sel_addr,
  output logic        sel_ena,
  input  logic [31:0] sel_data
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG, OWN_DUMP} owner_t;

  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       force_dbg;
  logic       dump_issue;

  // Debug overtakes core once it has watched STARVE_LIMIT core grants go by.
  always_comb begin
    force_dbg = d_req && (starve_cnt == 4'(STARVE_LIMIT));
    c_gnt     = c_req && !force_dbg;
    d_gnt     = d_req && !c_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!d_req || d_gnt) begin
      starve_cnt <= '0;
    end else if (c_gnt) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Stage 0: drive the selector and remember who the read belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_addr <= '0;
      sel_ena  <= 1'b1;
      owner    <= OWN_NONE;
    end else begin
      sel_ena <= 1'b0;
      if (c_gnt) begin
        sel_addr <= c_addr;
        owner    <= OWN_CORE;
      end else if (d_gnt) begin
        sel_addr <= d_addr;
        owner    <= OWN_DBG;
      end else if (dump_issue) begin
        sel_addr <= dump_idx;
        owner    <= OWN_DUMP;
      end else begin
        sel_ena  <= 1'b1;
        owner    <= OWN_NONE;
      end
    end
  end

  // Stage 1: capture selector output for core/debug; rdata holds between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata    <= '0;
      c_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      c_rvalid <= (owner == OWN_CORE);
      d_rvalid <= (owner == OWN_DBG);
      if (owner == OWN_CORE || owner == OWN_DBG) begin
        rdata <= sel_data;
      end
    end
  end

`ifdef RF_ARB_DUMP_EN
  typedef enum logic {DUMP_IDLE, DUMP_RUN} dump_state_t;

  dump_state_t dump_state;

  assign dump_busy = (dump_state == DUMP_RUN);

  // One entry at a time: a new read issues only once the buffer is empty and nothing is in flight.
  assign dump_issue = (dump_state == DUMP_RUN) && !c_gnt && !d_gnt &&
                      !dump_valid && (owner != OWN_DUMP);

  // dump_valid/dump_ready: an entry transfers on any cycle both are high; while valid is
  // high and ready low, dump_idx and dump_data are held unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_state <= DUMP_IDLE;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      if (owner == OWN_DUMP) begin
        dump_data  <= sel_data;
        dump_valid <= 1'b1;
      end
      case (dump_state)
        DUMP_IDLE: begin
          if (dump_start) begin
            dump_state <= DUMP_RUN;
          end
        end
        DUMP_RUN: begin
          if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_idx == 5'd31) begin
              dump_done  <= 1'b1;
              dump_state <= DUMP_IDLE;
              dump_idx   <= '0;
            end else begin
              dump_idx <= dump_idx + 5'd1;
            end
          end
        end
        default: dump_state <= DUMP_IDLE;
      endcase
    end
  end
`else
  logic unused_dump_in;

  assign unused_dump_in = dump_start ^ dump_ready;
  assign dump_issue     = 1'b0;
  assign dump_busy      = 1'b0;
  assign dump_valid     = 1'b0;
  assign dump_done      = 1'b0;
  assign dump_idx       = '0;
  assign dump_data      = '0;
`endif

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: directed stimulus against a cycle-level transaction model,
// plus hand-computed literal checks on the headline scenarios.
module tb_rf_read_arbiter;

  localparam int STARVE_LIMIT = 4;
`ifdef RF_ARB_DUMP_EN
  localparam bit DUMP_EN = 1'b1;
`else
  localparam bit DUMP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        c_req = 1'b0, d_req = 1'b0;
  logic [4:0]  c_addr = '0, d_addr = '0;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
  logic [31:0] rdata;
  logic        dump_start = 1'b0, dump_ready = 1'b0;
  logic        dump_busy, dump_valid, dump_done;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;
  logic [4:0]  sel_addr;
  logic        sel_ena;
  logic [31:0] sel_data;

  rf_read_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_addr(c_addr), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .rdata(rdata),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done),
    .sel_addr(sel_addr), .sel_ena(sel_ena), .sel_data(sel_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // register file contents: low byte 0xA0+addr, top byte addr^5 (so addr 5 reads 0x000000A5)
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return {3'b000, a ^ 5'd5, 24'h0000A0} + {27'b0, a};
  endfunction

  assign sel_data = sel_ena ? 32'hDEAD_BEEF : rf_val(sel_addr);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: expected read returns, keyed by the cycle they must appear in
  typedef struct {
    int          due;
    int          kind;
    logic [31:0] data;
  } ev_t;
  ev_t exp_q[$];

  int          m_starve = 0;
  logic [4:0]  m_sel_addr = '0;
  logic        m_sel_ena = 1'b1;
  logic [31:0] m_rdata = '0, m_ddata = '0;
  logic        m_busy = 1'b0, m_dvalid = 1'b0, m_done = 1'b0, m_pending = 1'b0;
  logic [4:0]  m_idx = '0;
  int          n_acc = 0, n_done = 0;

  always @(negedge clk) begin : cmp
    logic e_c, e_d, g_c, g_d, iss;
    ev_t  ev;
    if (rst) begin
      exp_q.delete();
      m_starve = 0; m_sel_addr = '0; m_sel_ena = 1'b1; m_rdata = '0; m_ddata = '0;
      m_busy = 1'b0; m_dvalid = 1'b0; m_done = 1'b0; m_pending = 1'b0; m_idx = '0;
      chk("rst_sel_ena", 32'(sel_ena), 32'd1);
      chk("rst_sel_addr", 32'(sel_addr), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      chk("rst_dump_busy", 32'(dump_busy), 32'd0);
      chk("rst_dump_valid", 32'(dump_valid), 32'd0);
      chk("rst_dump_idx", 32'(dump_idx), 32'd0);
      chk("rst_dump_data", dump_data, 32'd0);
      chk("rst_dump_done", 32'(dump_done), 32'd0);
    end else begin
      e_c = 1'b0;
      e_d = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        ev = exp_q.pop_front();
        case (ev.kind)
          1: begin e_c = 1'b1; m_rdata = ev.data; end
          2: begin e_d = 1'b1; m_rdata = ev.data; end
          default: begin m_dvalid = 1'b1; m_ddata = ev.data; end
        endcase
      end
      g_d = d_req && (!c_req || m_starve >= STARVE_LIMIT);
      g_c = c_req && !g_d;
      iss = m_busy && !g_c && !g_d && !m_pending;

      chk("c_gnt", 32'(c_gnt), 32'(g_c));
      chk("d_gnt", 32'(d_gnt), 32'(g_d));
      chk("c_rvalid", 32'(c_rvalid), 32'(e_c));
      chk("d_rvalid", 32'(d_rvalid), 32'(e_d));
      chk("rdata", rdata, m_rdata);
      chk("sel_ena", 32'(sel_ena), 32'(m_sel_ena));
      chk("sel_addr", 32'(sel_addr), 32'(m_sel_addr));
      chk("dump_busy", 32'(dump_busy), 32'(m_busy));
      chk("dump_valid", 32'(dump_valid), 32'(m_dvalid));
      chk("dump_idx", 32'(dump_idx), 32'(m_idx));
      chk("dump_data", dump_data, m_ddata);
      chk("dump_done", 32'(dump_done), 32'(m_done));
      if (dump_valid && dump_ready) n_acc++;
      if (dump_done) n_done++;

      // advance model to the next cycle
      if (g_c) begin
        exp_q.push_back('{cyc + 2, 1, rf_val(c_addr)});
        m_sel_addr = c_addr; m_sel_ena = 1'b0;
      end else if (g_d) begin
        exp_q.push_back('{cyc + 2, 2, rf_val(d_addr)});
        m_sel_addr = d_addr; m_sel_ena = 1'b0;
      end else if (iss) begin
        exp_q.push_back('{cyc + 2, 3, rf_val(m_idx)});
        m_pending = 1'b1;
        m_sel_addr = m_idx; m_sel_ena = 1'b0;
      end else begin
        m_sel_ena = 1'b1;
      end
      m_starve = (g_c && d_req) ? m_starve + 1 : 0;
      m_done = 1'b0;
      if (m_dvalid && dump_ready) begin
        m_dvalid = 1'b0;
        m_pending = 1'b0;
        if (m_idx == 5'd31) begin
          m_done = 1'b1; m_busy = 1'b0; m_idx = '0;
        end else begin
          m_idx = m_idx + 5'd1;
        end
      end
      if (dump_start && !m_busy && DUMP_EN) m_busy = 1'b1;
    end
  end

  logic [14:0] gpat;
  int          stall;
  bit          pinned, got;

  initial begin
    repeat (3) tick;
    rst = 1'b0;
    tick;

    // core read of address 5
    c_req = 1'b1; c_addr = 5'd5;
    @(negedge clk); chk("t1_c_gnt", 32'(c_gnt), 32'd1);
    tick; c_req = 1'b0;
    @(negedge clk);
    chk("t1_sel_addr", 32'(sel_addr), 32'd5);
    chk("t1_sel_ena", 32'(sel_ena), 32'd0);
    tick;
    @(negedge clk);
    chk("t1_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("t1_rdata", rdata, 32'h0000_00A5);
    tick;

    // core and debug both held: four core grants then one forced debug grant
    gpat = '0;
    c_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      c_addr = 5'(i); d_addr = 5'(31 - i);
      @(negedge clk); gpat = {gpat[13:0], d_gnt};
      tick;
    end
    c_req = 1'b0; d_req = 1'b0;
    chk("t2_starve_pattern", 32'(gpat), 32'(15'b000010000100001));
    repeat (3) tick;

    // mixed directed traffic, including address 0
    for (int i = 0; i < 8; i++) begin
      c_req = i[0]; c_addr = 5'(i * 3);
      d_req = (i != 3); d_addr = 5'd0;
      tick;
    end
    c_req = 1'b0; d_req = 1'b0;
    repeat (3) tick;

    // reset the cycle after a core grant: the read must vanish
    c_req = 1'b1; c_addr = 5'd9;
    @(negedge clk); chk("t4_c_gnt", 32'(c_gnt), 32'd1);
    tick; c_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t4_sel_ena", 32'(sel_ena), 32'd1);
    chk("t4_rdata", rdata, 32'd0);
    tick; rst = 1'b0;
    @(negedge clk); chk("t4_no_rvalid", 32'(c_rvalid), 32'd0);
    tick;

    // full dump with consumer always ready
    n_acc = 0; n_done = 0; got = 1'b0;
    dump_ready = 1'b1; dump_start = 1'b1;
    tick; dump_start = 1'b0;
    @(negedge clk); chk("t5_busy_rise", 32'(dump_busy), 32'(DUMP_EN));
    tick;
    for (int k = 0; k < 150 && !got; k++) begin
      @(negedge clk);
      if (dump_done) got = 1'b1;
      tick;
    end
    repeat (3) tick;
    chk("t5_done_seen", 32'(got), 32'(DUMP_EN));
    chk("t5_entries", 32'(n_acc), DUMP_EN ? 32'd32 : 32'd0);
    chk("t5_done_count", 32'(n_done), DUMP_EN ? 32'd1 : 32'd0);
    chk("t5_busy_fall", 32'(dump_busy), 32'd0);

    // dump with a 10-cycle stall at entry 7 and core/debug traffic mixed in
    n_acc = 0; n_done = 0; stall = 0; pinned = 1'b0;
    dump_start = 1'b1;
    tick; dump_start = 1'b0;
    for (int k = 0; k < 400 && n_done == 0; k++) begin
      dump_ready = !(dump_valid && dump_idx == 5'd7 && stall < 10);
      if (!dump_ready) stall++;
      c_req = (k % 7 == 3); c_addr = 5'(k);
      d_req = (k % 11 == 5); d_addr = 5'(31 - k);
      @(negedge clk);
`ifdef RF_ARB_DUMP_EN
      if (stall == 5 && !pinned) begin
        pinned = 1'b1;
        chk("t6_stall_valid", 32'(dump_valid), 32'd1);
        chk("t6_stall_idx", 32'(dump_idx), 32'd7);
        chk("t6_stall_data", dump_data, 32'h0200_00A7);
      end
`endif
      tick;
    end
    c_req = 1'b0; d_req = 1'b0; dump_ready = 1'b1;
    repeat (3) tick;
    chk("t6_stall_cycles", 32'(stall), DUMP_EN ? 32'd10 : 32'd0);
    chk("t6_entries", 32'(n_acc), DUMP_EN ? 32'd32 : 32'd0);
    chk("t6_done_count", 32'(n_done), DUMP_EN ? 32'd1 : 32'd0);

    // reset in the middle of a dump: aborted, no done pulse
    n_done = 0;
    dump_start = 1'b1;
    tick; dump_start = 1'b0;
    repeat (20) tick;
    rst = 1'b1;
    tick; rst = 1'b0;
    repeat (5) tick;
    chk("t7_abort_no_done", 32'(n_done), 32'd0);
    chk("t7_abort_idle", 32'(dump_busy), 32'd0);

    // core read after everything else
    c_req = 1'b1; c_addr = 5'd31;
    tick; c_req = 1'b0;
    tick;
    @(negedge clk);
    chk("t8_c_rvalid", 32'(c_rvalid), 32'd1);
    chk("t8_rdata", rdata, 32'h1A00_00BF);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
